// File: rtl/pipelined_tree_adder_if.sv
// Window-adder bus: per-beat window samples in, window sum and frame totals out.
// Handshake: a beat is transferred on every rising clk edge where in_valid=1;
// there is no ready, the adder accepts one window per clock. sum_valid marks a
// cycle where sum carries a new window result; acc_valid is a one-cycle pulse
// marking a new frame total on acc/acc_count/acc_ovf.
interface pipelined_tree_adder_if #(
  parameter int WIDTH     = 9,
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int ACC_EXTRA = 8
);
  localparam int N      = ROWS * COLS;
  localparam int LEVELS = $clog2(N);
  localparam int SUM_W  = WIDTH + 1 + LEVELS;
  localparam int ACC_W  = SUM_W + ACC_EXTRA;

  logic                    in_valid;
  logic                    in_last;
  logic                    abs_mode;
  logic signed [WIDTH-1:0] data_in [ROWS][COLS];
  logic                    sum_valid;
  logic signed [SUM_W-1:0] sum;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc;
  logic [15:0]             acc_count;
  logic                    acc_ovf;
  logic                    dbg_state;  // accumulator FSM state (0 idle, 1 accumulating)

  modport master (
    output in_valid, in_last, abs_mode, data_in,
    input  sum_valid, sum, acc_valid, acc, acc_count, acc_ovf, dbg_state
  );

  modport slave (
    input  in_valid, in_last, abs_mode, data_in,
    output sum_valid, sum, acc_valid, acc, acc_count, acc_ovf, dbg_state
  );
endinterface

// File: rtl/pipelined_tree_adder.sv
// Pipelined ROWS x COLS window tree adder with per-beat SAD mode and a
// saturating frame accumulator driven by in_last.
module pipelined_tree_adder #(
  parameter int WIDTH     = 9,
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int REG_EVERY = 1,
  parameter int ACC_EXTRA = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_tree_adder_if.slave  bus
);
  localparam int N      = ROWS * COLS;
  localparam int LEVELS = $clog2(N);
  localparam int NP     = 1 << LEVELS;
  localparam int SUM_W  = WIDTH + 1 + LEVELS;
  localparam int ACC_W  = SUM_W + ACC_EXTRA;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Sign-extend one extra bit first so that negating -2^(WIDTH-1) is exact.
  function automatic logic signed [SUM_W-1:0] leaf_val(input logic signed [WIDTH-1:0] x,
                                                       input logic abs_m);
    logic signed [WIDTH:0] w_x;
    w_x = {x[WIDTH-1], x};
    if (abs_m && w_x[WIDTH]) w_x = -w_x;
    leaf_val = SUM_W'(w_x);
  endfunction

  logic signed [SUM_W-1:0] r_leaf [N];
  logic                    r_v0;
  logic                    r_l0;

  // Stage 0: capture the window as (optionally absolute) full-width leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_l0 <= 1'b0;
      for (int i = 0; i < N; i++) r_leaf[i] <= '0;
    end else begin
      r_v0 <= bus.in_valid;
      r_l0 <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            r_leaf[r*COLS+c] <= leaf_val(bus.data_in[r][c], bus.abs_mode);
      end
    end
  end

  // Adder tree: level k holds NP>>k partial sums. Levels are registered every
  // REG_EVERY levels and always at the last level; others are pure wiring.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int CNT = NP >> k;
    logic signed [SUM_W-1:0] w_out [CNT];
    logic                    w_v;
    logic                    w_l;

    if (k == 0) begin : g_leaf
      for (genvar j = 0; j < NP; j++) begin : g_pad
        if (j < N) begin : g_real
          assign w_out[j] = r_leaf[j];
        end else begin : g_zero
          assign w_out[j] = '0;
        end
      end
      assign w_v = r_v0;
      assign w_l = r_l0;
    end else begin : g_add
      logic signed [SUM_W-1:0] w_add [CNT];
      for (genvar j = 0; j < CNT; j++) begin : g_pair
        assign w_add[j] = g_lvl[k-1].w_out[2*j] + g_lvl[k-1].w_out[2*j+1];
      end

      if ((k % REG_EVERY == 0) || (k == LEVELS)) begin : g_reg
        logic signed [SUM_W-1:0] r_node [CNT];
        logic                    r_v;
        logic                    r_l;
        // Data only advances with a valid beat, so the final stage holds sum across bubbles.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_v <= 1'b0;
            r_l <= 1'b0;
            for (int i = 0; i < CNT; i++) r_node[i] <= '0;
          end else begin
            r_v <= g_lvl[k-1].w_v;
            r_l <= g_lvl[k-1].w_l;
            if (g_lvl[k-1].w_v) begin
              for (int i = 0; i < CNT; i++) r_node[i] <= w_add[i];
            end
          end
        end
        assign w_out = r_node;
        assign w_v   = r_v;
        assign w_l   = r_l;
      end else begin : g_comb
        assign w_out = w_add;
        assign w_v   = g_lvl[k-1].w_v;
        assign w_l   = g_lvl[k-1].w_l;
      end
    end
  end

  logic signed [SUM_W-1:0] w_sum;
  logic                    w_sum_valid;
  logic                    w_sum_last;
  assign w_sum       = g_lvl[LEVELS].w_out[0];
  assign w_sum_valid = g_lvl[LEVELS].w_v;
  assign w_sum_last  = g_lvl[LEVELS].w_l;

  // Frame accumulator
  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;
  state_t                  r_state, w_state_nxt;
  logic signed [ACC_W-1:0] r_acc_reg, w_acc_reg_nxt;
  logic [15:0]             r_cnt, w_cnt_nxt;
  logic                    r_sat, w_sat_nxt;
  logic                    r_acc_valid, w_acc_valid_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [15:0]             r_acc_count, w_acc_count_nxt;
  logic                    r_acc_ovf, w_acc_ovf_nxt;
  logic signed [ACC_W-1:0] w_base, w_total;
  logic [15:0]             w_base_cnt, w_tot_cnt;
  logic                    w_base_sat, w_tot_sat;
  logic signed [ACC_W:0]   w_wide;

  // Accumulator state and frame-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc_reg   <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_acc_valid <= 1'b0;
      r_acc       <= '0;
      r_acc_count <= '0;
      r_acc_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_reg   <= w_acc_reg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sat       <= w_sat_nxt;
      r_acc_valid <= w_acc_valid_nxt;
      r_acc       <= w_acc_nxt;
      r_acc_count <= w_acc_count_nxt;
      r_acc_ovf   <= w_acc_ovf_nxt;
    end
  end

  // Next state: an IDLE beat starts from zero, an ACCUM beat adds with clamping;
  // a last beat publishes the total and returns to IDLE with the running state cleared.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_reg_nxt   = r_acc_reg;
    w_cnt_nxt       = r_cnt;
    w_sat_nxt       = r_sat;
    w_acc_valid_nxt = 1'b0;
    w_acc_nxt       = r_acc;
    w_acc_count_nxt = r_acc_count;
    w_acc_ovf_nxt   = r_acc_ovf;
    w_base          = '0;
    w_base_cnt      = '0;
    w_base_sat      = 1'b0;
    if (r_state == S_ACCUM) begin
      w_base     = r_acc_reg;
      w_base_cnt = r_cnt;
      w_base_sat = r_sat;
    end
    w_wide    = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_sum);
    w_total   = w_wide[ACC_W-1:0];
    w_tot_sat = w_base_sat;
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      w_total   = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      w_tot_sat = 1'b1;
    end
    w_tot_cnt = (w_base_cnt == 16'hFFFF) ? 16'hFFFF : w_base_cnt + 16'd1;
    if (w_sum_valid) begin
      if (w_sum_last) begin
        w_acc_valid_nxt = 1'b1;
        w_acc_nxt       = w_total;
        w_acc_count_nxt = w_tot_cnt;
        w_acc_ovf_nxt   = w_tot_sat;
        w_acc_reg_nxt   = '0;
        w_cnt_nxt       = '0;
        w_sat_nxt       = 1'b0;
        w_state_nxt     = S_IDLE;
      end else begin
        w_acc_reg_nxt   = w_total;
        w_cnt_nxt       = w_tot_cnt;
        w_sat_nxt       = w_tot_sat;
        w_state_nxt     = S_ACCUM;
      end
    end
  end

  assign bus.sum_valid = w_sum_valid;
  assign bus.sum       = w_sum;
  assign bus.acc_valid = r_acc_valid;
  assign bus.acc       = r_acc;
  assign bus.acc_count = r_acc_count;
  assign bus.acc_ovf   = r_acc_ovf;
  assign bus.dbg_state = r_state;
endmodule
